// File: rtl/uart_transmitter.sv
// 8N1 UART transmit engine: buffered valid/ready byte input, oversampled bit timing from clken_i.
// Define UART_TX_FIFO_EN for a 2^FIFO_AW-entry FIFO; otherwise a single holding register buffers one byte.
module uart_transmitter #(
   parameter int FIFO_AW    = 4,
   parameter int OVERSAMPLE = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clken_i,
   input  logic [7:0]         din_8b_i,
   input  logic               din_valid_i,
   output logic               din_ready_o,
   output logic               tx_o,
   output logic               busy_o,
   output logic [FIFO_AW:0]   fifo_count_o
);

   localparam int                TICK_W    = 4;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [FIFO_AW:0]  CNT_ONE   = (FIFO_AW + 1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [2:0]          bit_q, bit_d;
   logic [7:0]          shift_q, shift_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic [FIFO_AW:0]    cnt_q, cnt_d;
   logic                push, pop;
   logic                tick_end;
   logic [7:0]          head;

   assign push = din_valid_i && din_ready_o;

`ifdef UART_TX_FIFO_EN
   localparam int               DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;

   assign din_ready_o = (cnt_q != CNT_FULL);
   assign head        = mem[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_q] <= din_8b_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
         end
      end
   end
`else
   logic [7:0] hold_q;

   // Holding register is full exactly when the count is 1, so push and pop never coincide.
   assign din_ready_o = (cnt_q == '0);
   assign head        = hold_q;

   always_ff @(posedge clk_i) begin
      if (push) begin
         hold_q <= din_8b_i;
      end
   end
`endif

   assign tick_end = (tick_q == TICK_LAST);

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      if (clken_i) begin
         case (state_q)
            IDLE: begin
               tx_d = 1'b1;
               if (cnt_q != '0) begin
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  tick_d  = '0;
                  state_d = START;
               end
            end
            START: begin
               if (tick_end) begin
                  tick_d  = '0;
                  tx_d    = shift_q[0];
                  bit_d   = '0;
                  state_d = DATA;
               end else begin
                  tick_d = tick_q + TICK_ONE;
               end
            end
            DATA: begin
               if (tick_end) begin
                  tick_d = '0;
                  if (bit_q == 3'd7) begin
                     tx_d    = 1'b1;
                     state_d = STOP;
                  end else begin
                     shift_d = {1'b0, shift_q[7:1]};
                     tx_d    = shift_q[1];
                     bit_d   = bit_q + 3'd1;
                  end
               end else begin
                  tick_d = tick_q + TICK_ONE;
               end
            end
            STOP: begin
               if (tick_end) begin
                  tick_d = '0;
                  // Chain straight into the next start bit when a byte is waiting.
                  if (cnt_q != '0) begin
                     pop     = 1'b1;
                     shift_d = head;
                     tx_d    = 1'b0;
                     state_d = START;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  tick_d = tick_q + TICK_ONE;
               end
            end
            default: begin
               tx_d    = 1'b1;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (!push && pop) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   assign busy_d = (state_d != IDLE) || (cnt_d != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      shift_q <= shift_d;
   end

   assign tx_o         = tx_q;
   assign busy_o       = busy_q;
   assign fifo_count_o = cnt_q;

endmodule
